// File: rtl/video_pattern_gen.sv
`default_nettype none
// video_pattern_gen: 720p test-pattern pixel stage with 2-cycle latency to RGB, syncs and de.
// Optional overlay macro: PATGEN_CROSSHAIR_EN (green centre crosshair).
module video_pattern_gen #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int BAR_SPEED   = 4,
  parameter int BAR_WIDTH   = 64,
  parameter int AUTO_FRAMES = 120
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_in,
  input  logic [11:0] pixel_count,
  input  logic [11:0] line_count,
  input  logic [2:0]  mode_sel,
  input  logic        auto_en,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [7:0]  frame_cnt
);

  localparam logic [0:0]  c_ST_MANUAL = 1'b0;
  localparam logic [0:0]  c_ST_AUTO   = 1'b1;
  localparam logic [11:0] c_B1        = 12'(1 * (H_ACTIVE / 8));
  localparam logic [11:0] c_B2        = 12'(2 * (H_ACTIVE / 8));
  localparam logic [11:0] c_B3        = 12'(3 * (H_ACTIVE / 8));
  localparam logic [11:0] c_B4        = 12'(4 * (H_ACTIVE / 8));
  localparam logic [11:0] c_B5        = 12'(5 * (H_ACTIVE / 8));
  localparam logic [11:0] c_B6        = 12'(6 * (H_ACTIVE / 8));
  localparam logic [11:0] c_B7        = 12'(7 * (H_ACTIVE / 8));
  localparam logic [11:0] c_X_LAST    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] c_Y_LAST    = 12'(V_ACTIVE - 1);
  localparam logic [12:0] c_H_ACTIVE  = 13'(H_ACTIVE);
  localparam logic [12:0] c_BAR_SPEED = 13'(BAR_SPEED);
  localparam logic [12:0] c_BAR_WIDTH = 13'(BAR_WIDTH);
  localparam logic [7:0]  c_AUTO_LAST = 8'(AUTO_FRAMES - 1);
`ifdef PATGEN_CROSSHAIR_EN
  localparam logic [11:0] c_X_MID     = 12'(H_ACTIVE / 2);
  localparam logic [11:0] c_Y_MID     = 12'(V_ACTIVE / 2);
`endif

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [2:0]  r_mode;
  logic [2:0]  w_mode_nxt;
  logic [7:0]  r_auto_cnt;
  logic [7:0]  w_auto_cnt_nxt;
  logic        r_vsync_d;
  logic        w_fs;
  logic [11:0] r_bar_pos;
  logic [12:0] w_bar_step;
  logic [12:0] w_bar_end;
  logic        w_in_bar;
  logic [7:0]  r_frame_cnt;
  logic [23:0] w_pat;
  logic [23:0] r_s1_rgb;
  logic        r_s1_hs, r_s1_vs, r_s1_de;
  logic [23:0] r_rgb;
  logic        r_hs, r_vs, r_de;

  assign w_fs       = vsync_in & ~r_vsync_d;
  assign w_bar_step = {1'b0, r_bar_pos} + c_BAR_SPEED;
  assign w_bar_end  = {1'b0, r_bar_pos} + c_BAR_WIDTH;
  // 13-bit end keeps the bar clipped at the right edge instead of wrapping.
  assign w_in_bar   = (pixel_count >= r_bar_pos) && ({1'b0, pixel_count} < w_bar_end);

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_state    <= c_ST_MANUAL;
      r_mode     <= 3'd0;
      r_auto_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_auto_cnt <= w_auto_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_fs) w_state_nxt = auto_en ? c_ST_AUTO : c_ST_MANUAL;
  end

  always_comb begin
    w_mode_nxt     = r_mode;
    w_auto_cnt_nxt = r_auto_cnt;
    if (w_fs) begin
      if (!auto_en) begin
        w_mode_nxt = mode_sel;
      end else if (r_state == c_ST_MANUAL) begin
        w_mode_nxt     = 3'd0;
        w_auto_cnt_nxt = 8'd0;
      end else if (r_auto_cnt == c_AUTO_LAST) begin
        w_mode_nxt     = r_mode + 3'd1;
        w_auto_cnt_nxt = 8'd0;
      end else begin
        w_auto_cnt_nxt = r_auto_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_vsync_d   <= 1'b0;
      r_bar_pos   <= 12'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_vsync_d <= vsync_in;
      if (w_fs) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_bar_pos   <= (w_bar_step >= c_H_ACTIVE) ? 12'd0 : w_bar_step[11:0];
      end
    end
  end

  always_comb begin
    w_pat = 24'h000000;
    case (r_mode)
      3'd0: begin
        if      (pixel_count < c_B1) w_pat = 24'hFFFFFF;
        else if (pixel_count < c_B2) w_pat = 24'hFFFF00;
        else if (pixel_count < c_B3) w_pat = 24'h00FFFF;
        else if (pixel_count < c_B4) w_pat = 24'h00FF00;
        else if (pixel_count < c_B5) w_pat = 24'hFF00FF;
        else if (pixel_count < c_B6) w_pat = 24'hFF0000;
        else if (pixel_count < c_B7) w_pat = 24'h0000FF;
        else                         w_pat = 24'h000000;
      end
      3'd1: w_pat = {3{pixel_count[9:2]}};
      3'd2: w_pat = (pixel_count[5] ^ line_count[5]) ? 24'hFFFFFF : 24'h000000;
      3'd3: w_pat = w_in_bar ? 24'hFFFFFF : 24'h0000FF;
      3'd4: w_pat = 24'hFF0000;
      3'd5: w_pat = 24'h00FF00;
      3'd6: w_pat = 24'h0000FF;
      default: begin
        if (pixel_count == 12'd0 || pixel_count == c_X_LAST ||
            line_count == 12'd0 || line_count == c_Y_LAST)
          w_pat = 24'hFFFFFF;
      end
    endcase
`ifdef PATGEN_CROSSHAIR_EN
    if (pixel_count == c_X_MID || line_count == c_Y_MID) w_pat = 24'h00FF00;
`endif
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_s1_rgb <= 24'd0;
      r_s1_hs  <= 1'b0;
      r_s1_vs  <= 1'b0;
      r_s1_de  <= 1'b0;
      r_rgb    <= 24'd0;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
      r_de     <= 1'b0;
    end else begin
      r_s1_rgb <= w_pat;
      r_s1_hs  <= hsync_in;
      r_s1_vs  <= vsync_in;
      r_s1_de  <= active_in;
      r_rgb    <= r_s1_de ? r_s1_rgb : 24'd0;
      r_hs     <= r_s1_hs;
      r_vs     <= r_s1_vs;
      r_de     <= r_s1_de;
    end
  end

  assign red       = r_rgb[23:16];
  assign green     = r_rgb[15:8];
  assign blue      = r_rgb[7:0];
  assign hsync_out = r_hs;
  assign vsync_out = r_vs;
  assign de_out    = r_de;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// tb_video_pattern_gen: directed stimulus, arithmetic reference model and per-cycle compare.
module tb_video_pattern_gen;
  localparam int H  = 1280;
  localparam int V  = 720;
  localparam int BS = 4;
  localparam int BW = 64;
  localparam int AF = 2;

  logic        pixel_clock = 1'b0;
  logic        reset;
  logic        hsync_in, vsync_in, active_in, auto_en;
  logic [11:0] pixel_count, line_count;
  logic [2:0]  mode_sel;
  logic [7:0]  red, green, blue, frame_cnt;
  logic        hsync_out, vsync_out, de_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int          m_mode, m_bar, m_fcnt, m_n;
  bit          m_auto, m_vsd;
  logic [23:0] exp_rgb [2];
  logic        exp_h [2];
  logic        exp_v [2];
  logic        exp_de [2];

  video_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BAR_SPEED(BS), .BAR_WIDTH(BW), .AUTO_FRAMES(AF)
  ) dut (
    .pixel_clock(pixel_clock), .reset(reset),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
    .pixel_count(pixel_count), .line_count(line_count),
    .mode_sel(mode_sel), .auto_en(auto_en),
    .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .frame_cnt(frame_cnt)
  );

  always #5 pixel_clock = ~pixel_clock;

  function automatic logic [23:0] m_pat(input int mode, input int bar, input int x, input int y);
    logic [23:0] p;
    int          g;
    p = 24'h000000;
    case (mode)
      0: case (x / (H / 8))
           0: p = 24'hFFFFFF;
           1: p = 24'hFFFF00;
           2: p = 24'h00FFFF;
           3: p = 24'h00FF00;
           4: p = 24'hFF00FF;
           5: p = 24'hFF0000;
           6: p = 24'h0000FF;
           default: p = 24'h000000;
         endcase
      1: begin g = (x / 4) % 256; p = {8'(g), 8'(g), 8'(g)}; end
      2: p = (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      3: p = (x >= bar && x < bar + BW) ? 24'hFFFFFF : 24'h0000FF;
      4: p = 24'hFF0000;
      5: p = 24'h00FF00;
      6: p = 24'h0000FF;
      default: p = (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? 24'hFFFFFF : 24'h000000;
    endcase
`ifdef PATGEN_CROSSHAIR_EN
    if (x == H / 2 || y == V / 2) p = 24'h00FF00;
`endif
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_bar = 0; m_fcnt = 0; m_n = 0; m_auto = 1'b0; m_vsd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_rgb[i] = 24'h0; exp_h[i] = 1'b0; exp_v[i] = 1'b0; exp_de[i] = 1'b0;
    end
  endtask

  // Called right after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    if (!reset) begin
      exp_rgb[1] = exp_rgb[0]; exp_h[1] = exp_h[0]; exp_v[1] = exp_v[0]; exp_de[1] = exp_de[0];
      exp_h[0]   = hsync_in;
      exp_v[0]   = vsync_in;
      exp_de[0]  = active_in;
      exp_rgb[0] = active_in ? m_pat(m_mode, m_bar, int'(pixel_count), int'(line_count)) : 24'h0;
      if (vsync_in && !m_vsd) begin
        m_fcnt = (m_fcnt + 1) % 256;
        m_bar  = (m_bar + BS >= H) ? 0 : m_bar + BS;
        if (auto_en) begin
          if (!m_auto) begin m_auto = 1'b1; m_n = 0; end
          else m_n = m_n + 1;
          m_mode = (m_n / AF) % 8;
        end else begin
          m_auto = 1'b0;
          m_mode = int'(mode_sel);
        end
      end
      m_vsd = vsync_in;
    end
  endtask

  task automatic cyc(input logic h, input logic v, input logic a, input int x, input int y);
    hsync_in = h; vsync_in = v; active_in = a;
    pixel_count = 12'(x); line_count = 12'(y);
    @(posedge pixel_clock);
    model_edge();
    #2;
  endtask

  task automatic px(input int x, input int y);
    cyc(1'b0, 1'b0, 1'b1, x, y);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic fsync();
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic lit(input string name, input logic [23:0] act, input logic [23:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", name, act, exp_v);
    end
  endtask

  always @(negedge pixel_clock) begin
    if (chk_en) begin
      checks++;
      if ({red, green, blue} !== exp_rgb[1]) begin
        errors++;
        $display("FAIL rgb @%0t: actual %h expected %h", $time, {red, green, blue}, exp_rgb[1]);
      end
      checks++;
      if ({hsync_out, vsync_out, de_out} !== {exp_h[1], exp_v[1], exp_de[1]}) begin
        errors++;
        $display("FAIL hs/vs/de @%0t: actual %b expected %b", $time,
                 {hsync_out, vsync_out, de_out}, {exp_h[1], exp_v[1], exp_de[1]});
      end
      checks++;
      if (frame_cnt !== 8'(m_fcnt)) begin
        errors++;
        $display("FAIL frame_cnt @%0t: actual %0d expected %0d", $time, frame_cnt, m_fcnt);
      end
    end
  end

  initial begin
    reset = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; active_in = 1'b0;
    pixel_count = 12'd0; line_count = 12'd0; mode_sel = 3'd0; auto_en = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) idle();
    lit("reset rgb", 24'({red, green, blue}), 24'h000000);
    lit("reset syncs/de", 24'({hsync_out, vsync_out, de_out}), 24'h0);
    lit("reset frame_cnt", 24'(frame_cnt), 24'h0);
    reset = 1'b0;
    idle();

    // Moving bar after three frame starts sits at x = 12..75
    mode_sel = 3'd3;
    repeat (3) fsync();
    px(11, 5); px(12, 5);
    lit("bar x11", 24'({red, green, blue}), 24'h0000FF);
    px(75, 5);
    lit("bar x12", 24'({red, green, blue}), 24'hFFFFFF);
    px(76, 5);
    lit("bar x75", 24'({red, green, blue}), 24'hFFFFFF);
    idle();
    lit("bar x76", 24'({red, green, blue}), 24'h0000FF);

    // Colour bars
    mode_sel = 3'd0;
    fsync();
    lit("frame_cnt after 4 fs", 24'(frame_cnt), 24'd4);
    px(0, 10); px(160, 10);
    lit("bars x0", 24'({red, green, blue}), 24'hFFFFFF);
    px(1279, 10);
    lit("bars x160", 24'({red, green, blue}), 24'hFFFF00);
    idle();
    lit("bars x1279", 24'({red, green, blue}), 24'h000000);

    // hsync two-cycle delay
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    lit("hsync N+1", 24'(hsync_out), 24'd0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    lit("hsync N+2", 24'(hsync_out), 24'd1);
    idle(); idle();

    // Solid red, blanked when inactive
    mode_sel = 3'd4;
    fsync();
    cyc(1'b0, 1'b0, 1'b0, 100, 10);
    px(100, 10);
    lit("mode4 inactive rgb", 24'({red, green, blue}), 24'h000000);
    lit("mode4 inactive de", 24'(de_out), 24'd0);
    idle();
    lit("mode4 active rgb", 24'({red, green, blue}), 24'hFF0000);

    // Mid-frame mode change takes effect only at the next frame start
    mode_sel = 3'd0;
    fsync();
    px(200, 10);
    mode_sel = 3'd2;
    px(200, 10);
    lit("midframe before", 24'({red, green, blue}), 24'hFFFF00);
    idle();
    lit("midframe still bars", 24'({red, green, blue}), 24'hFFFF00);
    fsync();
    px(200, 10); px(224, 10);
    lit("checker x200", 24'({red, green, blue}), 24'h000000);
    idle();
    lit("checker x224", 24'({red, green, blue}), 24'hFFFFFF);

    // frame_cnt wrap 255 -> 0
    mode_sel = 3'd7;
    for (int g = 0; g < 400 && m_fcnt != 255; g++) fsync();
    lit("frame_cnt 255", 24'(frame_cnt), 24'hFF);
    px(0, 300); px(5, 0);
    lit("border x0", 24'({red, green, blue}), 24'hFFFFFF);
    fsync();
    lit("frame_cnt wrap", 24'(frame_cnt), 24'h00);

    // Bar clipping at the right edge and bar_pos wrap
    mode_sel = 3'd3;
    fsync();
    for (int g = 0; g < 400 && m_bar != 1276; g++) fsync();
    px(1279, 20); px(0, 20);
    lit("bar clip x1279", 24'({red, green, blue}), 24'hFFFFFF);
    idle();
    lit("bar no wrap x0", 24'({red, green, blue}), 24'h0000FF);
    fsync();
    px(0, 20); px(64, 20);
    lit("bar reset x0", 24'({red, green, blue}), 24'hFFFFFF);
    idle();
    lit("bar reset x64", 24'({red, green, blue}), 24'h0000FF);

    // Auto mode: two frames per pattern, mode_sel ignored
    auto_en = 1'b1; mode_sel = 3'd5;
    fsync();
    px(200, 10); idle();
    lit("auto first mode0", 24'({red, green, blue}), 24'hFFFF00);
    fsync();
    mode_sel = 3'd6;
    fsync();
    px(400, 10); idle();
    lit("auto mode1 ramp", 24'({red, green, blue}), 24'h646464);
    for (int i = 0; i < 14; i++) begin
      mode_sel = 3'(i);
      fsync();
      px(400 + i, 30); idle();
    end
    px(200, 10); idle();
    lit("auto wrap to mode0", 24'({red, green, blue}), 24'hFFFF00);
    auto_en = 1'b0; mode_sel = 3'd2;
    fsync();
    px(224, 10); idle();

    // Reset during active video
    px(100, 10); px(101, 10);
    reset = 1'b1;
    model_reset();
    #1;
    lit("async reset rgb", 24'({red, green, blue}), 24'h000000);
    lit("async reset syncs/de", 24'({hsync_out, vsync_out, de_out}), 24'h0);
    lit("async reset frame_cnt", 24'(frame_cnt), 24'h0);
    #1;
    idle(); idle();
    reset = 1'b0;
    mode_sel = 3'd5;
    fsync();
    px(10, 10); idle();
    lit("post-reset mode5", 24'({red, green, blue}), 24'h00FF00);
    idle(); idle();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
Pixel stage directly downstream of the 720p sync/timing generator. It consumes the generator's hsync, vsync, active, pixel_count and line_count, and produces 24-bit RGB plus re-timed syncs and data-enable for the TMDS/HDMI encoder. It provides eight selectable test patterns and an auto-cycling mode for bring-up of the DPI-to-HDMI display path without a Raspberry Pi source.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines per frame
BAR_SPEED, 4, moving-bar advance in pixels per frame
BAR_WIDTH, 64, moving-bar width in pixels
AUTO_FRAMES, 120, frames per pattern in auto mode (1..255)

Ports:
pixel_clock  in  1  pixel clock (74.25 MHz)
reset  in  1  asynchronous, active-high reset
hsync_in  in  1  horizontal sync from timing generator
vsync_in  in  1  vertical sync from timing generator
active_in  in  1  active-video flag from timing generator
pixel_count  in  12  horizontal position, 0..H_ACTIVE-1 while active
line_count  in  12  vertical position, 0..V_ACTIVE-1 while active
mode_sel  in  3  manual pattern select
auto_en  in  1  1 = cycle patterns automatically
red  out  8  red component
green  out  8  green component
blue  out  8  blue component
hsync_out  out  1  hsync_in delayed to align with RGB
vsync_out  out  1  vsync_in delayed to align with RGB
de_out  out  1  active_in delayed to align with RGB
frame_cnt  out  8  frame counter, wraps 255->0

Behaviour:
- Reset (async): red/green/blue/hsync_out/vsync_out/de_out = 0, frame_cnt = 0, mode register = 0, bar_pos = 0, auto frame counter = 0, vsync_d = 0, state = MANUAL.
- Latency: fixed 2 pixel_clock cycles from inputs to all outputs. Syncs and de go through a 2-stage delay. Stage 1 registers the pattern decode; stage 2 registers RGB.
- RGB is forced to 0x000000 whenever the stage-2 de is 0.
- Frame start (fs): vsync_in = 1 and vsync_d = 0, where vsync_d is vsync_in registered on pixel_clock.
- The following update only on fs, never mid-frame:
  - the mode register;
  - bar_pos;
  - frame_cnt (+1);
  - the auto counter.
- State machine:
  - MANUAL: on fs, mode <= mode_sel.
  - If auto_en = 1 at fs: go to AUTO, mode <= 0, auto counter <= 0.
  - AUTO: on fs, auto counter +1. When it reaches AUTO_FRAMES-1, counter <= 0 and mode <= mode+1 (wraps 7->0).
  - If auto_en = 0 at fs: go to MANUAL, mode <= mode_sel.
  - In AUTO, mode_sel is ignored.
- Patterns (x = pixel_count, y = line_count):
  - 0, colour bars: 8 equal bars of width H_ACTIVE/8, in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. Bar boundaries are elaboration-time constant comparisons; no divider.
  - 1, gray ramp: R = G = B = x[9:2]; wraps every 1024 pixels.
  - 2, checker 32x32: x[5]^y[5] = 1 -> FFFFFF, else 000000.
  - 3, moving bar: bar_pos <= x < bar_pos+BAR_WIDTH -> FFFFFF, else 0000FF. On fs, bar_pos += BAR_SPEED; if bar_pos+BAR_SPEED >= H_ACTIVE, bar_pos <= 0. The bar is clipped at the right edge, with no wrap of the drawn bar.
  - 4 solid FF0000; 5 solid 00FF00; 6 solid 0000FF.
  - 7, border: FFFFFF when x = 0, x = H_ACTIVE-1, y = 0 or y = V_ACTIVE-1; else 000000.
- bar_pos and frame_cnt advance every fs regardless of mode.
- Reset mid-frame: outputs drop to 0 immediately. After release, the first fs latches mode normally; up to 2 cycles of delay-line flush is not an error.

Optional Feature:
PATGEN_CROSSHAIR_EN
- Defined: a 1-pixel green (00FF00) crosshair overrides the pattern where x = H_ACTIVE/2 or y = V_ACTIVE/2. This applies in all modes, still gated by de, with latency unchanged.
- Undefined: no overlay logic, and pattern output is exactly as above.

Test Plan:
- Manual mode_sel=0, after one fs, line 10 -> RGB at x=0 FFFFFF, x=160 FFFF00, x=1279 000000, each appearing 2 cycles after the input pixel.
- hsync_in rising at cycle N -> hsync_out rising at N+2. mode 4 with active_in=0 -> RGB 000000 and de_out=0.
- mode 3 after 3 fs -> bar_pos=12: x=12..75 FFFFFF, x=76 0000FF. Preset bar_pos=1276 + fs -> bar_pos 0.
- AUTO_FRAMES=2, auto_en=1 -> mode sequence per fs 0,0,1,1,2,2..., 7 wraps to 0. Toggling mode_sel has no effect. frame_cnt 255 + fs -> 0.
- Change mode_sel 0->2 mid-frame -> output stays colour bars until the next fs, then checkerboard.
- Assert reset during active video -> RGB/syncs/de/frame_cnt = 0 that same cycle. Release, then fs with mode_sel=5 -> solid 00FF00.
